seq_skip_sub: RTL and testbench

- Multi-cycle N-bit two's-complement subtractor computing D = A - B as A + ~B + 1.
- Processes one 4-bit nibble per clock, LSB first, through a carry-skip nibble stage.
- Sits in the arithmetic datapath next to the carry-skip adders and trades latency for area.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/seq_skip_sub_pkg.sv | 13 +
 rtl/sub_nibble_skip.sv | 29 ++
 rtl/seq_skip_sub.sv | 105 ++++++++++
 tb/tb_seq_skip_sub.sv | 133 +++++++++++++
 4 files changed

// File: rtl/seq_skip_sub_pkg.sv
// Shared types and helpers for the nibble-serial carry-skip subtractor.
package seq_skip_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  localparam int unsigned NIB_W = 4;

  // Counter width for a given nibble count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/sub_nibble_skip.sv
// Combinational 4-bit add stage: ripple full-adder chain with a carry-skip term on cout.
module sub_nibble_skip
  import seq_skip_sub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] bn,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] g;
  logic [NIB_W:0]   c;

  always_comb begin
    p = a ^ bn;
    g = a & bn;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < int'(NIB_W); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s = p ^ c[NIB_W-1:0];
    // When every bit propagates, cin passes straight to cout.
    cout = c[NIB_W] | ((&p) & cin);
  end

endmodule

// File: rtl/seq_skip_sub.sv
// Multi-cycle N-bit subtractor D = A + ~B + 1, one nibble per clock, LSB first.
module seq_skip_sub
  import seq_skip_sub_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned NIB = N / NIB_W;
  localparam int unsigned CW  = cnt_width(NIB);

  if ((N % NIB_W) != 0 || N < NIB_W) begin : g_bad_n
    $error("seq_skip_sub: N must be a multiple of 4 and at least 4");
  end

  sub_state_t        state, state_nx;
  logic [N-1:0]      a_q, bn_q, diff_nx;
  logic [CW-1:0]     cnt;
  logic              carry, a_msb, b_msb;
  logic [NIB_W-1:0]  s;
  logic              c_out, last;

  sub_nibble_skip u_nib (
    .a    (a_q[NIB_W-1:0]),
    .bn   (bn_q[NIB_W-1:0]),
    .cin  (carry),
    .s    (s),
    .cout (c_out)
  );

  // Next-state and merged result for the current nibble.
  always_comb begin
    state_nx = state;
    last     = (cnt == CW'(NIB - 1));
    diff_nx  = diff;
    diff_nx[{cnt, 2'b00} +: NIB_W] = s;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      a_q       <= '0;
      bn_q      <= '0;
      carry     <= 1'b1;
      cnt       <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          bn_q  <= ~b;
          a_msb <= a[N-1];
          b_msb <= b[N-1];
          carry <= 1'b1;
          cnt   <= '0;
        end
        RUN: begin
          diff  <= diff_nx;
          carry <= c_out;
          a_q   <= a_q >> NIB_W;
          bn_q  <= bn_q >> NIB_W;
          cnt   <= cnt + CW'(1);
          if (last) begin
            borrow <= ~c_out;
            ovf    <= (a_msb != b_msb) & (s[NIB_W-1] != a_msb);
            zero   <= (diff_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_skip_sub.sv
// Directed self-checking bench for seq_skip_sub (N=16).
module tb_seq_skip_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        out_valid, out_ready;
  logic [15:0] diff;
  logic        borrow, ovf, zero;

  int n_checks = 0;
  int n_errors = 0;

  seq_skip_sub #(.N(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, check latency and result, optionally hold off the consumer.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                        input logic [15:0] ed, input logic eb, input logic eo,
                        input logic ez, input int stall);
    int lat;
    check("in_ready_before", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF;
    lat = 1;
    while (!out_valid && lat < 20) begin
      check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      tick();
      lat++;
    end
    lat--;
    check("latency", lat, 32'd4);
    check("diff", {16'd0, diff}, {16'd0, ed});
    check("borrow", {31'd0, borrow}, {31'd0, eb});
    check("ovf", {31'd0, ovf}, {31'd0, eo});
    check("zero", {31'd0, zero}, {31'd0, ez});
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = 16'h1111; b = 16'h2222;
      tick();
      in_valid = 1'b0;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_diff", {16'd0, diff}, {16'd0, ed});
      check("bp_flags", {29'd0, borrow, ovf, zero}, {29'd0, eb, eo, ez});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handoff_valid", {31'd0, out_valid}, 32'd0);
    check("handoff_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] ra, rb, rd;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {13'd0, diff, borrow, ovf, zero}, 32'd0);

    // out_ready with nothing pending must not disturb IDLE
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("idle_out_ready", {30'd0, in_ready, out_valid}, 32'd2);

    run_op(16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0);
    run_op(16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0, 3);
    run_op(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
    run_op(16'h0001, 16'h8000, 16'h8001, 1'b1, 1'b1, 1'b0, 1);

    // Reset at the second RUN edge discards the operation
    a = 16'h4321; b = 16'h1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrun_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrun_outputs", {13'd0, diff, borrow, ovf, zero}, 32'd0);
    tick(); tick(); tick();
    check("midrun_no_result", {31'd0, out_valid}, 32'd0);
    run_op(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0, 0);

    // A short sweep of pseudo-random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rd = ra - rb;
      run_op(ra, rb, rd, ra < rb, (ra[15] != rb[15]) && (rd[15] != ra[15]),
             rd == 16'd0, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
